convert_n_wide: RTL and testbench

CONVERT_N_WIDE -- requirements
Module: convert_n_wide

---
 rtl/convert_pkg.sv | 14 +
 rtl/convert_n_wide_if.sv | 32 +++
 rtl/convert_n_wide.sv | 133 +++++++++++++
 tb/tb_convert_n_wide.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/convert_pkg.sv
// Shared lane-order encodings and the beat-to-lane mapping used by the
// narrow-to-wide converter.
package convert_pkg;

  localparam int unsigned LSB_FIRST = 0;
  localparam int unsigned MSB_FIRST = 1;

  function automatic int unsigned lane_idx(input int unsigned beat,
                                           input int unsigned ratio,
                                           input int unsigned order);
    return (order == MSB_FIRST) ? (ratio - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/convert_n_wide_if.sv
// Stream bundle for convert_n_wide: a narrow beat stream in and a wide word
// stream out.
interface convert_n_wide_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RATIO = 8
);
  localparam int unsigned OUT_W = IN_W * RATIO;

  // Valid/ready: a beat or word moves on a rising edge where valid and ready
  // are both high; the source holds payload steady until that edge, and
  // ready never depends combinationally on valid.
  logic [IN_W-1:0]  i_data;
  logic             i_last;
  logic             i_rval;
  logic             o_rrdy;
  logic [OUT_W-1:0] o_data;
  logic [RATIO-1:0] o_keep;
  logic             o_last;
  logic             o_tval;
  logic             i_trdy;

  modport slave (
    input  i_data, i_last, i_rval, i_trdy,
    output o_rrdy, o_data, o_keep, o_last, o_tval
  );

  modport master (
    output i_data, i_last, i_rval, i_trdy,
    input  o_rrdy, o_data, o_keep, o_last, o_tval
  );

endinterface

// File: rtl/convert_n_wide.sv
// Packs RATIO narrow beats into one wide word with per-lane keep; i_last closes
// a word early. One accumulator plus one output register, pend on back-pressure.
module convert_n_wide
  import convert_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input logic              clk,
  input logic              reset,
  convert_n_wide_if.slave  bus
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned CW    = $clog2(RATIO);

  generate
    if (RATIO < 2 || IN_W < 1) begin : g_bad_params
      $error("convert_n_wide: RATIO must be >= 2 and IN_W >= 1");
    end
  endgenerate

  logic [OUT_W-1:0] acc_data_q, acc_data_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic             acc_last_q, acc_last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_tval_q, out_tval_d;

  logic             i_xfer, o_xfer, close, out_free;
  logic [CW-1:0]    lane;
  logic [OUT_W-1:0] mrg_data;
  logic [RATIO-1:0] mrg_keep;

  assign i_xfer   = bus.i_rval & ~pend_q;
  assign o_xfer   = out_tval_q & bus.i_trdy;
  assign close    = i_xfer & ((cnt_q == CW'(RATIO - 1)) | bus.i_last);
  assign out_free = ~out_tval_q | bus.i_trdy;
  assign lane     = CW'(lane_idx(32'(cnt_q), RATIO, MSB_FIRST));

  always_comb begin
    mrg_data = acc_data_q;
    mrg_keep = acc_keep_q;
    mrg_data[lane*IN_W +: IN_W] = bus.i_data;
    mrg_keep[lane]              = 1'b1;
  end

  always_comb begin
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    acc_last_d = acc_last_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    out_tval_d = out_tval_q;

    if (pend_q) begin
      // Input is blocked while a finished word waits; drain it first.
      if (o_xfer) begin
        out_data_d = acc_data_q;
        out_keep_d = acc_keep_q;
        out_last_d = acc_last_q;
        out_tval_d = 1'b1;
        pend_d     = 1'b0;
        acc_data_d = '0;
        acc_keep_d = '0;
        acc_last_d = 1'b0;
      end
    end else if (close) begin
      cnt_d = '0;
      if (out_free) begin
        out_data_d = mrg_data;
        out_keep_d = mrg_keep;
        out_last_d = bus.i_last;
        out_tval_d = 1'b1;
        acc_data_d = '0;
        acc_keep_d = '0;
        acc_last_d = 1'b0;
      end else begin
        acc_data_d = mrg_data;
        acc_keep_d = mrg_keep;
        acc_last_d = bus.i_last;
        pend_d     = 1'b1;
      end
    end else begin
      if (i_xfer) begin
        acc_data_d = mrg_data;
        acc_keep_d = mrg_keep;
        cnt_d      = cnt_q + 1'b1;
      end
      if (o_xfer) begin
        out_tval_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_last_q <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_tval_q <= 1'b0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      acc_last_q <= acc_last_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      out_tval_q <= out_tval_d;
    end
  end

  assign bus.o_rrdy = ~pend_q;
  assign bus.o_data = out_data_q;
  assign bus.o_keep = out_keep_q;
  assign bus.o_last = out_last_q;
  assign bus.o_tval = out_tval_q;

endmodule

// File: tb/tb_convert_n_wide.sv
// Bench for convert_n_wide: three configurations, directed literal checks plus
// a queue-based word model compared on every output transfer.
module tb_convert_n_wide;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int          sel      = 0;
  logic [15:0] drv_data = '0;
  logic        drv_last = 1'b0;
  logic        drv_rval = 1'b0;
  logic        drv_trdy = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  convert_n_wide_if #(.IN_W(8),  .RATIO(8)) b0 ();
  convert_n_wide_if #(.IN_W(8),  .RATIO(8)) b1 ();
  convert_n_wide_if #(.IN_W(16), .RATIO(4)) b2 ();

  convert_n_wide #(.IN_W(8),  .RATIO(8), .MSB_FIRST(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  convert_n_wide #(.IN_W(8),  .RATIO(8), .MSB_FIRST(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  convert_n_wide #(.IN_W(16), .RATIO(4), .MSB_FIRST(0)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  assign b0.i_data = drv_data[7:0];
  assign b1.i_data = drv_data[7:0];
  assign b2.i_data = drv_data;
  assign b0.i_last = drv_last;
  assign b1.i_last = drv_last;
  assign b2.i_last = drv_last;
  assign b0.i_rval = drv_rval && (sel == 0);
  assign b1.i_rval = drv_rval && (sel == 1);
  assign b2.i_rval = drv_rval && (sel == 2);
  assign b0.i_trdy = (sel == 0) ? drv_trdy : 1'b1;
  assign b1.i_trdy = (sel == 1) ? drv_trdy : 1'b1;
  assign b2.i_trdy = (sel == 2) ? drv_trdy : 1'b1;

  // ---------------- view of the active instance ----------------
  logic        m_rval, m_rrdy, m_last, m_tval, m_trdy, m_olast;
  logic [15:0] m_idata;
  logic [63:0] m_odata;
  logic [7:0]  m_okeep;
  int          m_in_w, m_ratio;
  bit          m_msb;

  always_comb begin
    m_rval = b0.i_rval; m_rrdy = b0.o_rrdy; m_last = b0.i_last; m_tval = b0.o_tval;
    m_trdy = b0.i_trdy; m_olast = b0.o_last; m_idata = {8'h00, b0.i_data};
    m_odata = b0.o_data; m_okeep = b0.o_keep; m_in_w = 8; m_ratio = 8; m_msb = 1'b0;
    if (sel == 1) begin
      m_rval = b1.i_rval; m_rrdy = b1.o_rrdy; m_last = b1.i_last; m_tval = b1.o_tval;
      m_trdy = b1.i_trdy; m_olast = b1.o_last; m_idata = {8'h00, b1.i_data};
      m_odata = b1.o_data; m_okeep = b1.o_keep; m_in_w = 8; m_ratio = 8; m_msb = 1'b1;
    end else if (sel == 2) begin
      m_rval = b2.i_rval; m_rrdy = b2.o_rrdy; m_last = b2.i_last; m_tval = b2.o_tval;
      m_trdy = b2.i_trdy; m_olast = b2.o_last; m_idata = b2.i_data;
      m_odata = b2.o_data; m_okeep = {4'h0, b2.o_keep}; m_in_w = 16; m_ratio = 4; m_msb = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- word model and compare process ----------------
  logic [15:0] part[8];
  int          n_part = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  exp_keep_q[$];
  logic        exp_last_q[$];
  int          words_out = 0;
  bit          prev_stall = 0, prev_trdy = 0, want_tval = 0;
  logic [63:0] prev_data, w_data;
  logic [7:0]  prev_keep, w_keep;
  logic        prev_last;
  int          w_lane;

  always @(negedge clk) begin
    if (reset) begin
      n_part = 0;
      exp_q.delete();
      exp_keep_q.delete();
      exp_last_q.delete();
      prev_stall = 0;
      prev_trdy  = 0;
      want_tval  = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_tval", 64'(m_tval), 64'd1);
        chk("hold_data", m_odata, prev_data);
        chk("hold_keep", 64'(m_okeep), 64'(prev_keep));
        chk("hold_last", 64'(m_olast), 64'(prev_last));
      end
      if (prev_trdy) chk("rrdy_no_backpressure", 64'(m_rrdy), 64'd1);
      if (want_tval) chk("close_latency", 64'(m_tval), 64'd1);
      want_tval = 0;

      if (m_tval && m_trdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_unexpected: got 0x%0h, want no word (t=%0t)", m_odata, $time);
        end else begin
          chk("word_data", m_odata, exp_q.pop_front());
          chk("word_keep", 64'(m_okeep), 64'(exp_keep_q.pop_front()));
          chk("word_last", 64'(m_olast), 64'(exp_last_q.pop_front()));
          words_out++;
        end
      end

      if (m_rval && m_rrdy) begin
        part[n_part] = m_idata;
        n_part++;
        if (n_part == m_ratio || m_last) begin
          w_data = '0;
          w_keep = '0;
          for (int i = 0; i < n_part; i++) begin
            w_lane = m_msb ? (m_ratio - 1 - i) : i;
            w_data = w_data | (64'(part[i]) << (w_lane * m_in_w));
            w_keep[w_lane] = 1'b1;
          end
          exp_q.push_back(w_data);
          exp_keep_q.push_back(w_keep);
          exp_last_q.push_back(m_last);
          n_part = 0;
          want_tval = !m_tval || m_trdy;
        end
      end

      prev_stall = m_tval && !m_trdy;
      prev_data  = m_odata;
      prev_keep  = m_okeep;
      prev_last  = m_olast;
      prev_trdy  = m_trdy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    chk("beat_offer_rrdy", 64'(m_rrdy), 64'd1);
    drv_data = d;
    drv_last = l;
    drv_rval = 1'b1;
    tick();
    drv_rval = 1'b0;
    drv_last = 1'b0;
  endtask

  task automatic chk_out0(input string name, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic v);
    chk({name, "_data"}, b0.o_data, d);
    chk({name, "_keep"}, 64'(b0.o_keep), 64'(k));
    chk({name, "_last"}, 64'(b0.o_last), 64'(l));
    chk({name, "_tval"}, 64'(b0.o_tval), 64'(v));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_words;
    int cyc;
    bit hold;

    // reset state
    reset = 1'b1;
    repeat (3) tick();
    chk_out0("rst0", 64'h0, 8'h00, 1'b0, 1'b0);
    chk("rst0_rrdy", 64'(b0.o_rrdy), 64'd1);
    chk("rst2_tval", 64'(b2.o_tval), 64'd0);
    chk("rst2_rrdy", 64'(b2.o_rrdy), 64'd1);
    reset = 1'b0;
    tick();

    // full LSB-first word, back-to-back
    sel = 0;
    drv_trdy = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i * 8'h11), 1'b0);
    chk_out0("lsb_word", 64'h8877665544332211, 8'hFF, 1'b0, 1'b1);
    tick();
    chk("lsb_word_drop_tval", 64'(b0.o_tval), 64'd0);

    // full MSB-first word
    sel = 1;
    for (int i = 1; i <= 8; i++) send(16'(i * 8'h11), 1'b0);
    chk("msb_word_data", b1.o_data, 64'h1122334455667788);
    chk("msb_word_keep", 64'(b1.o_keep), 64'hFF);
    chk("msb_word_tval", 64'(b1.o_tval), 64'd1);
    tick();

    // early close via i_last, then next beat lands in lane 0
    sel = 0;
    send(16'hA1, 1'b0);
    send(16'hA2, 1'b0);
    send(16'hA3, 1'b1);
    chk_out0("short_word", 64'h0000000000A3A2A1, 8'h07, 1'b1, 1'b1);
    send(16'h5A, 1'b1);
    chk_out0("after_short", 64'h000000000000005A, 8'h01, 1'b1, 1'b1);
    tick();

    // back-pressure: word 1 in output, word 2 pending
    drv_trdy = 1'b0;
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
    chk("stall_rrdy", 64'(b0.o_rrdy), 64'd0);
    chk_out0("stall_w1", 64'h0807060504030201, 8'hFF, 1'b0, 1'b1);
    tick();
    chk_out0("stall_w1_hold", 64'h0807060504030201, 8'hFF, 1'b0, 1'b1);
    drv_trdy = 1'b1;
    tick();
    chk_out0("stall_w2", 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 1'b1);
    chk("stall_w2_rrdy", 64'(b0.o_rrdy), 64'd1);
    tick();
    chk("stall_done_tval", 64'(b0.o_tval), 64'd0);

    // reset with a stalled word and a partial word in flight
    drv_trdy = 1'b0;
    for (int i = 0; i < 8; i++) send(16'(8'hC1 + i), 1'b0);
    for (int i = 0; i < 5; i++) send(16'(8'hE1 + i), 1'b0);
    reset = 1'b1;
    #1;
    chk_out0("midrst", 64'h0, 8'h00, 1'b0, 1'b0);
    chk("midrst_rrdy", 64'(b0.o_rrdy), 64'd1);
    drv_trdy = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    chk_out0("post_rst_word", 64'h0807060504030201, 8'hFF, 1'b0, 1'b1);
    tick();

    // wide configuration, random valid/ready/last
    sel = 2;
    tick();
    start_words = words_out;
    cyc  = 0;
    hold = 0;
    while ((words_out - start_words) < 1000 && cyc < 40000) begin
      drv_trdy = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        drv_rval = ($urandom_range(0, 3) != 0);
        drv_data = 16'($urandom_range(0, 65535));
        drv_last = ($urandom_range(0, 7) == 0);
      end
      hold = drv_rval && !m_rrdy;
      tick();
      cyc++;
    end
    drv_rval = 1'b0;
    drv_last = 1'b0;
    drv_trdy = 1'b1;
    repeat (6) tick();
    chk("rand_word_count_reached", 64'((words_out - start_words) >= 1000), 64'd1);
    chk("rand_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
